// File: rtl/dcache_wb_controller_pkg.sv
// Shared types, widths and address field helpers for the write-back data cache.
package dcache_wb_controller_pkg;

   localparam int LINE_W = 128;
   localparam int WORD_W = 32;
   localparam int ADDR_W = 30;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WRITEBACK = 2'd1,
      ALLOCATE  = 2'd2
   } state_e;

   // Word address layout: [1:0] word offset, then index, then tag.
   function automatic logic [ADDR_W-1:0] addr_tag(input logic [ADDR_W-1:0] a, input int idx_w);
      return a >> (idx_w + 2);
   endfunction

   function automatic logic [ADDR_W-1:0] addr_index(input logic [ADDR_W-1:0] a, input int idx_w);
      return (a >> 2) & ((ADDR_W'(1) << idx_w) - ADDR_W'(1));
   endfunction

   function automatic logic [1:0] addr_offset(input logic [ADDR_W-1:0] a);
      return a[1:0];
   endfunction

endpackage

// File: rtl/dcache_wb_controller_line_array.sv
// Tag/valid/dirty/data storage: one combinational read port, a word-write port
// (marks the line dirty) and a line-write port (fill: valid, clean).
module dcache_wb_controller_line_array
   import dcache_wb_controller_pkg::*;
#(
   parameter int IDX_W = 3,
   parameter int TAG_W = 28 - IDX_W
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [IDX_W-1:0]   idx_i,
   output logic               valid_o,
   output logic               dirty_o,
   output logic [TAG_W-1:0]   tag_o,
   output logic [LINE_W-1:0]  line_o,
   input  logic               ww_en_i,
   input  logic [1:0]         ww_off_i,
   input  logic [WORD_W-1:0]  ww_data_i,
   input  logic               lw_en_i,
   input  logic [TAG_W-1:0]   lw_tag_i,
   input  logic [LINE_W-1:0]  lw_line_i
);

   localparam int NLINES = 1 << IDX_W;

   logic [NLINES-1:0]             valid_q;
   logic [NLINES-1:0]             dirty_q;
   logic [TAG_W-1:0]              tag_q  [NLINES];
   logic [3:0][WORD_W-1:0]        data_q [NLINES];

   assign valid_o = valid_q[idx_i];
   assign dirty_o = dirty_q[idx_i];
   assign tag_o   = tag_q[idx_i];
   assign line_o  = data_q[idx_i];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
         dirty_q <= '0;
      end else if (lw_en_i) begin
         valid_q[idx_i] <= 1'b1;
         dirty_q[idx_i] <= 1'b0;
      end else if (ww_en_i) begin
         dirty_q[idx_i] <= 1'b1;
      end
   end

   // Payload storage carries no reset; valid bits gate its use.
   always_ff @(posedge clk) begin
      if (lw_en_i) begin
         tag_q[idx_i]  <= lw_tag_i;
         data_q[idx_i] <= lw_line_i;
      end else if (ww_en_i) begin
         data_q[idx_i][ww_off_i] <= ww_data_i;
      end
   end

endmodule

// File: rtl/dcache_wb_controller.sv
// Direct-mapped write-back, write-allocate data cache controller with a
// line-wide memory port; hits complete with zero added latency.
//
// state     | meaning
// IDLE      | serve hits; on miss choose write-back or allocate
// WRITEBACK | push dirty victim line to memory, wait for mem_ready
// ALLOCATE  | fetch requested line from memory, wait for mem_ready
module dcache_wb_controller
   import dcache_wb_controller_pkg::*;
#(
   parameter int IDX_W = 3
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                proc_read,
   input  logic                proc_write,
   input  logic [ADDR_W-1:0]   proc_addr,
   input  logic [WORD_W-1:0]   proc_wdata,
   output logic                proc_stall,
   output logic [WORD_W-1:0]   proc_rdata,
   output logic                mem_read,
   output logic                mem_write,
   output logic [27:0]         mem_addr,
   output logic [LINE_W-1:0]   mem_wdata,
   input  logic [LINE_W-1:0]   mem_rdata,
   input  logic                mem_ready
);

   localparam int TAG_W = 28 - IDX_W;

   state_e                 state_q, state_d;
   logic [TAG_W-1:0]       req_tag;
   logic [IDX_W-1:0]       req_idx;
   logic [1:0]             req_off;
   logic                   req, hit;
   logic                   line_valid, line_dirty;
   logic [TAG_W-1:0]       line_tag;
   logic [LINE_W-1:0]      line_data;
   logic [3:0][WORD_W-1:0] line_words;
   logic                   ww_en, lw_en;

   assign req_tag    = TAG_W'(addr_tag(proc_addr, IDX_W));
   assign req_idx    = IDX_W'(addr_index(proc_addr, IDX_W));
   assign req_off    = addr_offset(proc_addr);
   assign req        = proc_read | proc_write;
   assign hit        = line_valid && (line_tag == req_tag);
   assign line_words = line_data;

   dcache_wb_controller_line_array #(
      .IDX_W (IDX_W),
      .TAG_W (TAG_W)
   ) u_lines (
      .clk       (clk),
      .rst_n     (rst_n),
      .idx_i     (req_idx),
      .valid_o   (line_valid),
      .dirty_o   (line_dirty),
      .tag_o     (line_tag),
      .line_o    (line_data),
      .ww_en_i   (ww_en),
      .ww_off_i  (req_off),
      .ww_data_i (proc_wdata),
      .lw_en_i   (lw_en),
      .lw_tag_i  (req_tag),
      .lw_line_i (mem_rdata)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d    = state_q;
      proc_stall = 1'b0;
      proc_rdata = '0;
      ww_en      = 1'b0;
      lw_en      = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;
      unique case (state_q)
         IDLE: begin
            if (req) begin
               if (hit) begin
                  proc_rdata = line_words[req_off];
                  ww_en      = proc_write;
               end else begin
                  proc_stall = 1'b1;
                  state_d    = (line_valid && line_dirty) ? WRITEBACK : ALLOCATE;
               end
            end
         end
         WRITEBACK: begin
            // Victim stays readable here because nothing writes the array until the fill.
            proc_stall = 1'b1;
            mem_write  = 1'b1;
            mem_addr   = {line_tag, req_idx};
            mem_wdata  = line_data;
            if (mem_ready) state_d = ALLOCATE;
         end
         ALLOCATE: begin
            proc_stall = 1'b1;
            mem_read   = 1'b1;
            mem_addr   = proc_addr[ADDR_W-1:2];
            if (mem_ready) begin
               lw_en   = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_dcache_wb_controller.sv
// Self-checking bench: directed scenarios plus randomized accesses against a
// behavioural cache/memory model.
module tb_dcache_wb_controller;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         proc_read, proc_write;
   logic [29:0]  proc_addr;
   logic [31:0]  proc_wdata;
   logic         proc_stall;
   logic [31:0]  proc_rdata;
   logic         mem_read, mem_write;
   logic [27:0]  mem_addr;
   logic [127:0] mem_wdata, mem_rdata;
   logic         mem_ready;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   dcache_wb_controller #(.IDX_W(3)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .proc_read  (proc_read),
      .proc_write (proc_write),
      .proc_addr  (proc_addr),
      .proc_wdata (proc_wdata),
      .proc_stall (proc_stall),
      .proc_rdata (proc_rdata),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .mem_ready  (mem_ready)
   );

   // Reference model: cache contents and backing memory as plain arrays.
   bit           m_valid [8];
   bit           m_dirty [8];
   logic [24:0]  m_tag   [8];
   logic [127:0] m_line  [8];
   logic [127:0] mem     [int unsigned];

   task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   function automatic logic [127:0] mem_get(input int unsigned la);
      if (mem.exists(la)) return mem[la];
      return {32'h3000_0000 | la, 32'h2000_0000 | la, 32'h1000_0000 | la, 32'h0000_0000 | la};
   endfunction

   function automatic logic [127:0] rand128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   task automatic model_invalidate();
      for (int i = 0; i < 8; i++) begin
         m_valid[i] = 1'b0;
         m_dirty[i] = 1'b0;
      end
   endtask

   // Called just after a rising edge. dw/dr: memory cycles for write-back/fill.
   task automatic access(input bit rd, input bit wr, input logic [29:0] a,
                         input logic [31:0] wd, input int dw, input int dr);
      logic [2:0]   idx;
      logic [24:0]  tg;
      logic [1:0]   off;
      logic [27:0]  la, victim_la;
      logic [127:0] victim_line, fill_line, cur_line;
      logic [31:0]  exp_word;
      bit           hit, wb, exp_stall, exp_mw, exp_mr;
      int           n_wb, n_rd, total;

      idx = a[4:2];
      tg  = a[29:5];
      off = a[1:0];
      la  = a[29:2];
      hit = m_valid[idx] && (m_tag[idx] == tg);
      wb  = !hit && m_valid[idx] && m_dirty[idx];
      victim_la   = {m_tag[idx], idx};
      victim_line = m_line[idx];
      fill_line   = mem_get(32'(la));
      cur_line    = hit ? m_line[idx] : fill_line;
      exp_word    = cur_line[32*off +: 32];
      n_wb  = wb ? dw : 0;
      n_rd  = hit ? 0 : dr;
      total = hit ? 0 : 1 + n_wb + n_rd;

      proc_read  = rd;
      proc_write = wr;
      proc_addr  = a;
      proc_wdata = wd;

      for (int c = 0; c <= total; c++) begin
         @(negedge clk);
         exp_stall = (c < total);
         exp_mw    = (c >= 1) && (c <= n_wb);
         exp_mr    = (c > n_wb) && (c <= n_wb + n_rd);
         check("stall", proc_stall, exp_stall);
         check("mem_write", mem_write, exp_mw);
         check("mem_read", mem_read, exp_mr);
         if (exp_mw) begin
            check("wb_addr", mem_addr, victim_la);
            check("wb_data", mem_wdata, victim_line);
            if (c == n_wb) mem_ready = 1'b1;
         end
         if (exp_mr) begin
            check("fill_addr", mem_addr, la);
            if (c == n_wb + n_rd) begin
               mem_rdata = fill_line;
               mem_ready = 1'b1;
            end
         end
         if (!exp_stall && rd && !wr) check("rdata", proc_rdata, exp_word);
         @(posedge clk);
         #1;
         mem_ready = 1'b0;
         mem_rdata = rand128();
      end

      if (wb) mem[32'(victim_la)] = victim_line;
      if (!hit) begin
         m_valid[idx] = 1'b1;
         m_dirty[idx] = 1'b0;
         m_tag[idx]   = tg;
         m_line[idx]  = fill_line;
      end
      if (wr) begin
         m_line[idx][32*off +: 32] = wd;
         m_dirty[idx] = 1'b1;
      end
      proc_read  = 1'b0;
      proc_write = 1'b0;
   endtask

   task automatic idle_cycle();
      proc_addr = 30'($urandom());
      @(negedge clk);
      check("idle_stall", proc_stall, 1'b0);
      check("idle_rdata", proc_rdata, 32'h0);
      check("idle_mem", {mem_read, mem_write}, 2'b00);
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [29:0] a;
      logic [31:0] wd;
      int          kind;

      rst_n      = 1'b0;
      proc_read  = 1'b0;
      proc_write = 1'b0;
      proc_addr  = '0;
      proc_wdata = '0;
      mem_rdata  = '0;
      mem_ready  = 1'b0;
      model_invalidate();
      repeat (2) @(posedge clk);
      #1;
      check("rst_stall", proc_stall, 1'b0);
      check("rst_rdata", proc_rdata, 32'h0);
      check("rst_mem_rw", {mem_read, mem_write}, 2'b00);
      check("rst_mem_addr", mem_addr, 28'h0);
      check("rst_mem_wdata", mem_wdata, 128'h0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Line at address 4 holds {D,C,B,A}; ready arrives 4 cycles after mem_read rises.
      mem[4] = {32'hDDDD_DDDD, 32'hCCCC_CCCC, 32'hBBBB_BBBB, 32'hAAAA_AAAA};
      access(1, 0, 30'h10, 32'h0, 1, 5);
      access(1, 0, 30'h11, 32'h0, 1, 1);
      access(0, 1, 30'h12, 32'hDEAD_BEEF, 1, 1);
      access(1, 0, 30'h12, 32'h0, 1, 1);
      access(1, 0, 30'h110, 32'h0, 3, 2);
      idle_cycle();

      // Reset during ALLOCATE: requests drop at once, all lines invalidated.
      proc_read = 1'b1;
      proc_addr = 30'h210;
      @(negedge clk);
      @(negedge clk);
      check("pre_rst_mem_read", mem_read, 1'b1);
      rst_n = 1'b0;
      #1;
      check("async_rst_mem_read", mem_read, 1'b0);
      check("async_rst_mem_write", mem_write, 1'b0);
      @(posedge clk);
      #1;
      proc_read = 1'b0;
      rst_n     = 1'b1;
      model_invalidate();
      mem_ready = 1'b1;
      @(negedge clk);
      check("stray_ready_mem", {mem_read, mem_write}, 2'b00);
      @(posedge clk);
      #1;
      mem_ready = 1'b0;
      idle_cycle();
      access(1, 0, 30'h110, 32'h0, 1, 3);

      // Simultaneous read+write on a miss behaves as a store, then gets evicted.
      access(1, 1, 30'h20, 32'h1234_5678, 2, 2);
      access(1, 0, 30'h40, 32'h0, 2, 2);
      access(1, 0, 30'h20, 32'h0, 1, 1);

      for (int i = 0; i < 300; i++) begin
         a    = {23'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
         a    = {a[29:7] , a[6:0]};
         wd   = $urandom();
         kind = $urandom_range(0, 9);
         if (kind == 0)      idle_cycle();
         else if (kind <= 4) access(1, 0, a, wd, $urandom_range(1, 4), $urandom_range(1, 4));
         else if (kind <= 8) access(0, 1, a, wd, $urandom_range(1, 4), $urandom_range(1, 4));
         else                access(1, 1, a, wd, $urandom_range(1, 4), $urandom_range(1, 4));
      end

      // Read back every line the model holds to confirm stored data.
      for (int i = 0; i < 8; i++) begin
         if (m_valid[i]) begin
            for (int w = 0; w < 4; w++) begin
               access(1, 0, {m_tag[i], 3'(i), 2'(w)}, 32'h0, 1, 1);
            end
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Watchdog: bounded runtime with a reported failure.
   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

endmodule
